pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 104 ++++++++++
 tb/tb_pipe_stage_buf.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - ID->EXE elastic pipeline buffer with flush and stall statistics
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous discard of every buffered entry (branch taken)
//   in_valid   upstream entry offered
//   in_ready   room for one more entry; decoded from occupancy only
//   in_data    upstream payload
//   out_valid  head entry presented downstream
//   out_ready  downstream accepts the head entry
//   out_data   head payload, forced to zero (NOP bubble) when empty
//   count      current occupancy, 0..DEPTH
//   stall_cnt  saturating count of cycles where upstream was blocked

module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Pointers need at least one bit even when DEPTH is 1.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = $clog2(DEPTH) + 1;

    localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    logic push;
    logic pop;

    // Handshake flags come only from registered occupancy, so there is no
    // combinational path from out_ready to in_ready (no bypass when full).
    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Empty buffer presents an all-zero payload so EXE sees a NOP bubble.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // Explicit wrap keeps DEPTH=1 correct, where the pointer must stay at 0.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Blocked-cycle statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf

module tb_pipe_stage_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    always #5 clk = ~clk;

    // Instance A: DEPTH=2, CNT_W=16
    logic       rdy_a, vld_a;
    logic [7:0] dat_a;
    logic [1:0] cnt_a;
    logic [15:0] stl_a;
    // Instance B: DEPTH=1, CNT_W=2
    logic       rdy_b, vld_b;
    logic [7:0] dat_b;
    logic [0:0] cnt_b;
    logic [1:0] stl_b;
    // Instance C: DEPTH=4, CNT_W=4
    logic       rdy_c, vld_c;
    logic [7:0] dat_c;
    logic [2:0] cnt_c;
    logic [3:0] stl_c;

    pipe_stage_buf #(.DATA_W(8), .DEPTH(2), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
        .out_valid(vld_a), .out_ready(out_ready), .out_data(dat_a),
        .count(cnt_a), .stall_cnt(stl_a)
    );

    pipe_stage_buf #(.DATA_W(8), .DEPTH(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
        .out_valid(vld_b), .out_ready(out_ready), .out_data(dat_b),
        .count(cnt_b), .stall_cnt(stl_b)
    );

    pipe_stage_buf #(.DATA_W(8), .DEPTH(4), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_c), .in_data(in_data),
        .out_valid(vld_c), .out_ready(out_ready), .out_data(dat_c),
        .count(cnt_c), .stall_cnt(stl_c)
    );

    logic [31:0] o_cnt [3];
    logic [31:0] o_stl [3];
    logic [31:0] o_dat [3];
    logic        o_rdy [3];
    logic        o_vld [3];

    assign o_cnt[0] = 32'(cnt_a);
    assign o_cnt[1] = 32'(cnt_b);
    assign o_cnt[2] = 32'(cnt_c);
    assign o_stl[0] = 32'(stl_a);
    assign o_stl[1] = 32'(stl_b);
    assign o_stl[2] = 32'(stl_c);
    assign o_dat[0] = 32'(dat_a);
    assign o_dat[1] = 32'(dat_b);
    assign o_dat[2] = 32'(dat_c);
    assign o_rdy[0] = rdy_a;
    assign o_rdy[1] = rdy_b;
    assign o_rdy[2] = rdy_c;
    assign o_vld[0] = vld_a;
    assign o_vld[1] = vld_b;
    assign o_vld[2] = vld_c;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: each buffer is a bounded queue of payloads.
    typedef logic [7:0] q_t [$];
    q_t mq [3];
    int mstall [3] = '{0, 0, 0};
    int md     [3] = '{2, 1, 4};
    int smax   [3] = '{65535, 3, 15};
    bit m_ir;
    bit m_ov;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin
                    mq[i].delete();
                    mstall[i] = 0;
                end else begin
                    m_ir = (mq[i].size() < md[i]);
                    m_ov = (mq[i].size() > 0);
                    if (in_valid && !m_ir && mstall[i] < smax[i]) mstall[i]++;
                    if (flush) begin
                        mq[i].delete();
                    end else begin
                        if (m_ov && out_ready) void'(mq[i].pop_front());
                        if (in_valid && m_ir) mq[i].push_back(in_data);
                    end
                end
            end
        end
    end

    // Compare every observable output with the model on each falling edge.
    initial begin
        logic [31:0] exp_dat;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                exp_dat = (mq[i].size() > 0) ? 32'(mq[i][0]) : 32'd0;
                check($sformatf("count%0d", i), o_cnt[i], 32'(mq[i].size()));
                check($sformatf("in_ready%0d", i), 32'(o_rdy[i]), 32'(mq[i].size() < md[i]));
                check($sformatf("out_valid%0d", i), 32'(o_vld[i]), 32'(mq[i].size() > 0));
                check($sformatf("out_data%0d", i), o_dat[i], exp_dat);
                check($sformatf("stall_cnt%0d", i), o_stl[i], 32'(mstall[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic push_two(input logic [7:0] d0, input logic [7:0] d1);
        in_valid = 1'b1;
        in_data  = d0;
        step();
        in_data  = d1;
        step();
        in_valid = 1'b0;
    endtask

    int pushes_b;

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        step();
        check("rst_in_ready", 32'(rdy_a), 32'd1);
        check("rst_out_valid", 32'(vld_a), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_out_data", 32'(dat_a), 32'd0);
        check("rst_stall", 32'(stl_a), 32'd0);
        rst = 1'b1;

        // Fill then drain
        do_reset();
        out_ready = 1'b0;
        push_two(8'hA1, 8'hA2);
        check("fill_count", 32'(cnt_a), 32'd2);
        check("fill_in_ready", 32'(rdy_a), 32'd0);
        check("fill_head", 32'(dat_a), 32'hA1);
        out_ready = 1'b1;
        step();
        check("drain1_head", 32'(dat_a), 32'hA2);
        check("drain1_count", 32'(cnt_a), 32'd1);
        step();
        check("drain2_count", 32'(cnt_a), 32'd0);
        check("drain2_data", 32'(dat_a), 32'd0);
        check("drain2_valid", 32'(vld_a), 32'd0);

        // Backpressure statistics, including CNT_W=2 saturation on B
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        repeat (7) step();
        in_valid = 1'b0;
        check("stall_a", 32'(stl_a), 32'd5);
        check("stall_b_sat", 32'(stl_b), 32'd3);

        // Flush beats push and pop
        do_reset();
        out_ready = 1'b0;
        push_two(8'hB1, 8'hB2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hB3;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 32'(cnt_a), 32'd0);
        check("flush_valid", 32'(vld_a), 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("flush_no_b3", 32'(vld_a), 32'd0);
        end

        // Streaming 1..10; DEPTH=1 instance alternates in_ready
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pushes_b  = 0;
        for (int k = 1; k <= 10; k++) begin
            in_data = 8'(k);
            if (rdy_b) pushes_b++;
            step();
            check("stream_data", 32'(dat_a), 32'(k));
            check("stream_count", 32'(cnt_a), 32'd1);
            check("d1_in_ready", 32'(rdy_b), 32'((k % 2) == 0));
        end
        in_valid = 1'b0;
        check("d1_throughput", 32'(pushes_b), 32'd5);

        // Asynchronous reset between edges
        do_reset();
        out_ready = 1'b0;
        push_two(8'hD1, 8'hD2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(vld_a), 32'd0);
        check("arst_in_ready", 32'(rdy_a), 32'd1);
        check("arst_count", 32'(cnt_a), 32'd0);
        check("arst_data", 32'(dat_a), 32'd0);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hC1;
        step();
        in_valid = 1'b0;
        check("arst_head", 32'(dat_a), 32'hC1);
        check("arst_head_count", 32'(cnt_a), 32'd1);

        // Randomized traffic; the falling-edge checker compares against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = (n < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 99) < 3);
            in_data   = 8'($urandom);
            rst       = ($urandom_range(0, 299) != 0);
            step();
        end
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
